// File: rtl/ram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter_if
//
// Purpose: bundles the two requester handshakes and the RAM pin group that the
// ram_port_arbiter sits between.
//
// Signal summary:
//   pX_req    requester -> arbiter   access request, held until pX_gnt
//   pX_rw     requester -> arbiter   1 = write, 0 = read
//   pX_addr   requester -> arbiter   8-bit word address
//   pX_wdata  requester -> arbiter   32-bit write data
//   pX_gnt    arbiter -> requester   one-cycle grant pulse
//   pX_done   arbiter -> requester   one-cycle completion pulse
//   pX_rdata  arbiter -> requester   last read result for that port
//   ram_addr  arbiter -> RAM         word address
//   ram_din   arbiter -> RAM         write data
//   ram_en    arbiter -> RAM         enable
//   ram_rw    arbiter -> RAM         direction, 1 = write
//   ram_dout  RAM -> arbiter         read data
//
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding environment (requesters plus the RAM)
// -----------------------------------------------------------------------------
interface ram_port_arbiter_if;
    logic        p0_req;
    logic        p0_rw;
    logic [7:0]  p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_done;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_rw;
    logic [7:0]  p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_done;
    logic [31:0] p1_rdata;

    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_en;
    logic        ram_rw;
    logic [31:0] ram_dout;

    modport slave (
        input  p0_req, p0_rw, p0_addr, p0_wdata,
        input  p1_req, p1_rw, p1_addr, p1_wdata,
        input  ram_dout,
        output p0_gnt, p0_done, p0_rdata,
        output p1_gnt, p1_done, p1_rdata,
        output ram_addr, ram_din, ram_en, ram_rw
    );

    modport master (
        output p0_req, p0_rw, p0_addr, p0_wdata,
        output p1_req, p1_rw, p1_addr, p1_wdata,
        output ram_dout,
        input  p0_gnt, p0_done, p0_rdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  ram_addr, ram_din, ram_en, ram_rw
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Purpose: two-port access controller in front of a 256x32 word RAM. Accepts
// single-word read/write requests from two requesters, picks one, drives the
// RAM address/data/enable/direction lines for the access and returns read data
// with a one-cycle completion pulse. It is the only driver of the RAM inputs.
//
// Parameters:
//   RD_LAT   cycles ram_en is held for a read before ram_dout is captured (1..3)
//
// Ports:
//   clk      in   system clock, all state on the rising edge
//   rst_n    in   asynchronous active-low reset
//   bus      ram_port_arbiter_if.slave : requester handshakes and RAM pins
//
// Configuration macro:
//   RAM_ARB_RR_EN  defined     -> round-robin on contention (port that did not
//                                 win last is granted)
//                  not defined -> fixed priority, port 0 wins contention
//
// Sequencing: IDLE -> ACCESS (1 cycle for writes, RD_LAT cycles for reads)
// -> DONE -> IDLE. Every output is a register, so reset drops ram_en at once.
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Counter value on the final read cycle of an access.
    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic        winner_q, winner_d;   // port owning the current access (1 = port 1)
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        rw_q, rw_d;
    logic        en_q, en_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
`ifdef RAM_ARB_RR_EN
    logic        last_q, last_d;       // port that won the most recent grant
`endif

    logic        any_req_s;
    logic        win_s;
    logic        last_step_s;

    assign any_req_s   = bus.p0_req | bus.p1_req;
    // Writes occupy a single ACCESS cycle; reads run until the counter expires.
    assign last_step_s = rw_q | (cnt_q == LAST_CNT);

    // Arbitration: choose which requester wins in IDLE.
    always_comb begin
        if (bus.p0_req && bus.p1_req) begin
`ifdef RAM_ARB_RR_EN
            win_s = ~last_q;
`else
            win_s = 1'b0;
`endif
        end else if (bus.p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (last_step_s) begin
                    state_d = DONE;
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM output logic: next values of every registered output and datapath field.
    always_comb begin
        winner_d = winner_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        din_d    = din_q;
        rw_d     = rw_q;
        en_d     = en_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef RAM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    // Latch the winner's fields now; requester inputs are
                    // ignored for the rest of the access.
                    winner_d = win_s;
                    en_d     = 1'b1;
                    cnt_d    = 2'd0;
`ifdef RAM_ARB_RR_EN
                    last_d   = win_s;
`endif
                    if (win_s) begin
                        addr_d = bus.p1_addr;
                        din_d  = bus.p1_wdata;
                        rw_d   = bus.p1_rw;
                        gnt1_d = 1'b1;
                    end else begin
                        addr_d = bus.p0_addr;
                        din_d  = bus.p0_wdata;
                        rw_d   = bus.p0_rw;
                        gnt0_d = 1'b1;
                    end
                end else begin
                    en_d = 1'b0;
                end
            end
            ACCESS: begin
                if (last_step_s) begin
                    en_d = 1'b0;
                    if (winner_q) begin
                        done1_d = 1'b1;
                    end else begin
                        done0_d = 1'b1;
                    end
                    // Only reads update the winner's result register.
                    if (!rw_q && winner_q) begin
                        rdata1_d = bus.ram_dout;
                    end else if (!rw_q) begin
                        rdata0_d = bus.ram_dout;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                en_d = 1'b0;
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q <= 1'b0;
            cnt_q    <= 2'd0;
            addr_q   <= 8'h00;
            din_q    <= 32'h0000_0000;
            rw_q     <= 1'b0;
            en_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= 32'h0000_0000;
            rdata1_q <= 32'h0000_0000;
`ifdef RAM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            winner_q <= winner_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rw_q     <= rw_d;
            en_q     <= en_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef RAM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.ram_en   = en_q;
    assign bus.ram_rw   = rw_q;
    assign bus.p0_gnt   = gnt0_q;
    assign bus.p1_gnt   = gnt1_q;
    assign bus.p0_done  = done0_q;
    assign bus.p1_done  = done1_q;
    assign bus.p0_rdata = rdata0_q;
    assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Self-checking bench for ram_port_arbiter (RD_LAT = 3). A behavioural RAM sits
// on the RAM pins; a reference model (expected memory image, expected per-port
// read results, last-winner bookkeeping) predicts every checked value from the
// access rules and timing formulas: grant one cycle after the request edge,
// done RD_LAT+1 (read) or 2 (write) cycles after it.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int RD_LAT = 3;
`ifdef RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_port_arbiter_if bus ();

    ram_port_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM: synchronous write, asynchronous read.
    logic [31:0] ram_mem [256];
    logic        ram_clear = 1'b1;
    logic [7:0]  watch_addr = 8'hA5;
    int          watch_hits = 0;

    function automatic logic [31:0] seed_word(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= seed_word(8'(i));
        end else if (bus.ram_en && bus.ram_rw) begin
            ram_mem[bus.ram_addr] <= bus.ram_din;
        end
    end
    assign bus.ram_dout = ram_mem[bus.ram_addr];

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_addr == watch_addr) watch_hits <= watch_hits + 1;
    end

    // Reference model state.
    logic [31:0] mem_m [256];
    logic [31:0] exp_rd [2];
    int          last_w;
    int          vectors = 0;
    int          errors  = 0;

    function automatic int exp_winner(input bit r0, input bit r1);
        if (r0 && r1) return RR_EN ? ((last_w == 1) ? 0 : 1) : 0;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic gnt_of(input int p);
        return (p == 1) ? bus.p1_gnt : bus.p0_gnt;
    endfunction

    function automatic logic done_of(input int p);
        return (p == 1) ? bus.p1_done : bus.p0_done;
    endfunction

    task automatic set_req(input int port, input logic req, input logic rw,
                           input logic [7:0] addr, input logic [31:0] wd);
        if (port == 1) begin
            bus.p1_req = req; bus.p1_rw = rw; bus.p1_addr = addr; bus.p1_wdata = wd;
        end else begin
            bus.p0_req = req; bus.p0_rw = rw; bus.p0_addr = addr; bus.p0_wdata = wd;
        end
    endtask

    // One complete access from an idle arbiter, checking every cycle.
    task automatic do_access(input int port, input logic rw, input logic [7:0] addr,
                             input logic [31:0] wd, input string tag);
        int lat;
        int n;
        set_req(port, 1'b1, rw, addr, wd);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!gnt_of(port) && lat < 20);
        vectors++;
        if (gnt_of(port) !== 1'b1 || lat !== 1) begin
            errors++;
            $display("FAIL %s grant: got gnt=%b after %0d cycles, expected gnt=1 after 1", tag, gnt_of(port), lat);
        end
        last_w = port;
        vectors++;
        if ({gnt_of(1 - port), bus.ram_en, bus.ram_rw, bus.ram_addr} !== {1'b0, 1'b1, rw, addr}) begin
            errors++;
            $display("FAIL %s ram pins at grant: got othergnt/en/rw/addr=%b/%b/%b/%h expected 0/1/%b/%h",
                     tag, gnt_of(1 - port), bus.ram_en, bus.ram_rw, bus.ram_addr, rw, addr);
        end
        if (rw) begin
            vectors++;
            if (bus.ram_din !== wd) begin
                errors++;
                $display("FAIL %s ram_din: got %h expected %h", tag, bus.ram_din, wd);
            end
        end
        // Scrambled inputs after grant must not disturb the access.
        set_req(port, 1'b0, ~rw, ~addr, ~wd);
        n = rw ? 1 : RD_LAT;
        for (int k = 2; k <= n; k++) begin
            @(negedge clk);
            vectors++;
            if ({bus.ram_en, bus.ram_addr, bus.ram_rw, bus.p0_done, bus.p1_done} !== {1'b1, addr, rw, 2'b00}) begin
                errors++;
                $display("FAIL %s access cycle %0d: got en/addr/rw/done=%b/%h/%b/%b%b expected 1/%h/%b/00",
                         tag, k, bus.ram_en, bus.ram_addr, bus.ram_rw, bus.p0_done, bus.p1_done, addr, rw);
            end
        end
        @(negedge clk);
        if (rw) mem_m[addr] = wd;
        else    exp_rd[port] = mem_m[addr];
        vectors++;
        if (done_of(port) !== 1'b1 || done_of(1 - port) !== 1'b0 || bus.ram_en !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got done=%b other=%b en=%b expected 1/0/0",
                     tag, done_of(port), done_of(1 - port), bus.ram_en);
        end
        vectors++;
        if (bus.p0_rdata !== exp_rd[0] || bus.p1_rdata !== exp_rd[1]) begin
            errors++;
            $display("FAIL %s rdata: got %h/%h expected %h/%h", tag, bus.p0_rdata, bus.p1_rdata, exp_rd[0], exp_rd[1]);
        end
        @(negedge clk);
        vectors++;
        if ({bus.p0_done, bus.p1_done, bus.p0_gnt, bus.p1_gnt, bus.ram_en} !== 5'b00000) begin
            errors++;
            $display("FAIL %s after done: got done/gnt/en=%b%b/%b%b/%b expected all 0",
                     tag, bus.p0_done, bus.p1_done, bus.p0_gnt, bus.p1_gnt, bus.ram_en);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.ram_en, bus.ram_rw} !== 6'b0 ||
            bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0 ||
            bus.ram_addr !== 8'h00 || bus.ram_din !== 32'h0) begin
            errors++;
            $display("FAIL %s: got gnt=%b%b done=%b%b en=%b rw=%b addr=%h din=%h rdata=%h/%h expected all zero",
                     tag, bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.ram_en, bus.ram_rw,
                     bus.ram_addr, bus.ram_din, bus.p0_rdata, bus.p1_rdata);
        end
    endtask

    task automatic test_reset();
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b1, 1'b1, 8'h77, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        ram_clear = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 256; i++) mem_m[i] = seed_word(8'(i));
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        last_w = 1;
        rst_n = 1'b1;
        ram_clear = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_write_read();
        do_access(0, 1'b1, 8'h05, 32'hDEAD_BEEF, "p0_write_05");
        do_access(0, 1'b0, 8'h05, 32'h0, "p0_read_05");
        vectors++;
        if (bus.p0_rdata !== 32'hDEAD_BEEF || bus.p1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL p0_readback: got %h/%h expected deadbeef/00000000", bus.p0_rdata, bus.p1_rdata);
        end
    endtask

    task automatic test_bank_boundaries();
        logic [7:0]  a [4];
        logic [31:0] d [4];
        a[0] = 8'h3F; a[1] = 8'h40; a[2] = 8'hBF; a[3] = 8'hFF;
        d[0] = 32'h1111_1111; d[1] = 32'h2222_2222; d[2] = 32'h3333_3333; d[3] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) do_access(1, 1'b1, a[i], d[i], "bank_write");
        for (int i = 0; i < 4; i++) begin
            do_access(1, 1'b0, a[i], 32'h0, "bank_read");
            vectors++;
            if (bus.p1_rdata !== d[i]) begin
                errors++;
                $display("FAIL bank_value[%0d]: got %h expected %h", i, bus.p1_rdata, d[i]);
            end
        end
    endtask

    task automatic test_contention();
        localparam int NG = 8;
        int gcount = 0;
        int dcount = 0;
        int cyc = 0;
        int last_g_cyc = 0;
        int got;
        int pend_port = 0;
        logic [7:0] pend_addr = 8'h00;
        logic [7:0] a0, a1;
        a0 = 8'($urandom);
        a1 = 8'($urandom);
        set_req(0, 1'b1, 1'b0, a0, 32'h0);
        set_req(1, 1'b1, 1'b0, a1, 32'h0);
        while (dcount < NG && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.p0_gnt || bus.p1_gnt) begin
                got = bus.p1_gnt ? 1 : 0;
                vectors++;
                if ((bus.p0_gnt && bus.p1_gnt) || got !== exp_winner(1'b1, 1'b1)) begin
                    errors++;
                    $display("FAIL contention_winner #%0d: got gnt=%b%b expected port %0d",
                             gcount, bus.p1_gnt, bus.p0_gnt, exp_winner(1'b1, 1'b1));
                end
                if (gcount > 0) begin
                    vectors++;
                    if (cyc - last_g_cyc !== RD_LAT + 2) begin
                        errors++;
                        $display("FAIL contention_spacing: got %0d cycles expected %0d", cyc - last_g_cyc, RD_LAT + 2);
                    end
                end
                pend_port = got;
                pend_addr = (got == 1) ? a1 : a0;
                vectors++;
                if (bus.ram_addr !== pend_addr) begin
                    errors++;
                    $display("FAIL contention_addr: got %h expected %h", bus.ram_addr, pend_addr);
                end
                last_w = got;
                last_g_cyc = cyc;
                gcount++;
                if (gcount == NG) begin
                    set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
                    set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
                end else if (got == 1) begin
                    a1 = 8'($urandom);
                    set_req(1, 1'b1, 1'b0, a1, 32'h0);
                end else begin
                    a0 = 8'($urandom);
                    set_req(0, 1'b1, 1'b0, a0, 32'h0);
                end
            end
            if (bus.p0_done || bus.p1_done) begin
                exp_rd[pend_port] = mem_m[pend_addr];
                vectors++;
                if (done_of(pend_port) !== 1'b1 || done_of(1 - pend_port) !== 1'b0 ||
                    bus.p0_rdata !== exp_rd[0] || bus.p1_rdata !== exp_rd[1]) begin
                    errors++;
                    $display("FAIL contention_done: got done=%b%b rdata=%h/%h expected port %0d rdata=%h/%h",
                             bus.p1_done, bus.p0_done, bus.p0_rdata, bus.p1_rdata, pend_port, exp_rd[0], exp_rd[1]);
                end
                dcount++;
            end
        end
        vectors++;
        if (dcount !== NG) begin
            errors++;
            $display("FAIL contention_timeout: got %0d completions expected %0d", dcount, NG);
        end
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        int base;
        int p0_gnts = 0;
        int p1_dones = 0;
        base = watch_hits;
        set_req(1, 1'b1, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus.p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL withdraw_p1_gnt: got %b expected 1", bus.p1_gnt);
        end
        last_w = 1;
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(0, 1'b1, 1'b1, watch_addr, 32'h1234_5678);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.p0_gnt) p0_gnts++;
            if (bus.p1_done) begin
                p1_dones++;
                exp_rd[1] = mem_m[8'h10];
                vectors++;
                if (bus.p1_rdata !== exp_rd[1]) begin
                    errors++;
                    $display("FAIL withdraw_p1_rdata: got %h expected %h", bus.p1_rdata, exp_rd[1]);
                end
            end
        end
        vectors++;
        if (p0_gnts !== 0 || p1_dones !== 1 || watch_hits !== base) begin
            errors++;
            $display("FAIL withdraw: got p0_gnts=%0d p1_dones=%0d ram_hits=%0d expected 0/1/0",
                     p0_gnts, p1_dones, watch_hits - base);
        end
    endtask

    task automatic test_reset_mid_access();
        set_req(0, 1'b1, 1'b0, 8'h33, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus.p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midreset_gnt: got %b expected 1", bus.p0_gnt);
        end
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus.ram_en !== 1'b1) begin
            errors++;
            $display("FAIL midreset_en_before: got %b expected 1", bus.ram_en);
        end
        rst_n = 1'b0;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        last_w = 1;
        #1;
        check_reset_outputs("midreset_immediate");
        @(negedge clk);
        check_reset_outputs("midreset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.p0_done, bus.p1_done, bus.ram_en} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_no_done: got done=%b%b en=%b expected 000", bus.p0_done, bus.p1_done, bus.ram_en);
            end
        end
        do_access(0, 1'b0, 8'h33, 32'h0, "post_reset_read");
    endtask

    task automatic test_random();
        int port;
        logic rw;
        logic [7:0] addr;
        for (int i = 0; i < 24; i++) begin
            port = int'($urandom_range(0, 1));
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
            do_access(port, rw, addr, $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bank_boundaries();
        test_contention();
        test_withdraw();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
